// File: rtl/add_share_sched_if.sv
// add_share_sched_if
//   Bundle of the two requester ports, the response port and status for
//   add_share_sched.
//   slave  : seen by the scheduler (requests in, ready/response out)
//   master : seen by the requesters/consumer (requests out, response in)
//   Requester N: req_validN/req_readyN handshake, operands aN/bN, carry cinN.
//   Response   : resp_valid/resp_ready handshake, resp_id, sum, c_out, ovf.
//   busy       : scheduler is not idle.
interface add_share_sched_if;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] a0, b0, a1, b1;
  logic        cin0, cin1;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] sum;
  logic        c_out, ovf;
  logic        busy;

  modport slave (
    input  req_valid0, req_valid1, a0, b0, a1, b1, cin0, cin1, resp_ready,
    output req_ready0, req_ready1, resp_valid, resp_id, sum, c_out, ovf, busy
  );

  modport master (
    output req_valid0, req_valid1, a0, b0, a1, b1, cin0, cin1, resp_ready,
    input  req_ready0, req_ready1, resp_valid, resp_id, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/add_share_sched.sv
// add_share_sched
//   Two-requester 32-bit adder built around a single 16-bit carry-lookahead
//   core. An accepted request is added in two halves (LO then HI), the
//   result is presented in DONE until the consumer takes it.
//   Parameter RR_EN : 1 = round-robin arbitration, 0 = requester 0 always wins.
//   Ports: clk (rising edge), rst (synchronous, active high),
//          bus (add_share_sched_if.slave) carrying both requesters, the
//          response handshake, sum/c_out/ovf and busy.

// 4-bit lookahead block: local sum plus group generate/propagate for the LCU.
module cla4_blk (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gg,
  output logic       pg
);
  logic [3:0] g, p, c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;
endmodule

// 16-bit adder: four 4-bit blocks with a lookahead carry unit over them.
module CLA_16bit_withLCU (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [3:0] gg, pg;
  logic [4:0] cb;

  // Block carries straight from group G/P, no ripple between blocks.
  assign cb[0] = cin;
  assign cb[1] = gg[0] | (pg[0] & cin);
  assign cb[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign cb[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) |
                 (pg[2] & pg[1] & pg[0] & cin);
  assign cb[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) |
                 (pg[3] & pg[2] & pg[1] & gg[0]) |
                 (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  assign cout  = cb[4];

  for (genvar i = 0; i < 4; i++) begin : g_blk
    cla4_blk u_blk (
      .a   (a[4*i +: 4]),
      .b   (b[4*i +: 4]),
      .cin (cb[i]),
      .s   (sum[4*i +: 4]),
      .gg  (gg[i]),
      .pg  (pg[i])
    );
  end
endmodule

module add_share_sched #(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  add_share_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic        prio;            // requester holding priority
  logic        gnt;             // requester that would be granted now
  logic        rdy0, rdy1, acc;
  logic [31:0] a_r, b_r;
  logic        cin_r, id_r, carry_r;
  logic [31:0] sum_r;
  logic        c_out_r, ovf_r;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;

  // A lone valid wins outright; a tie goes to the priority holder.
  assign gnt = (bus.req_valid0 & bus.req_valid1) ? prio : bus.req_valid1;

  always_comb begin
    state_nxt = state;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          rdy0 = bus.req_valid0 & ~gnt;
          rdy1 = bus.req_valid1 &  gnt;
          if (rdy0 | rdy1) state_nxt = LO;
        end
      end
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign acc = rdy0 | rdy1;

  // One core, two passes: low half with the request carry, high half with
  // the carry registered out of the low pass.
  always_comb begin
    add_a   = a_r[15:0];
    add_b   = b_r[15:0];
    add_cin = cin_r;
    if (state == HI) begin
      add_a   = a_r[31:16];
      add_b   = b_r[31:16];
      add_cin = carry_r;
    end
  end

  CLA_16bit_withLCU u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      cin_r   <= 1'b0;
      id_r    <= 1'b0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        a_r   <= gnt ? bus.a1   : bus.a0;
        b_r   <= gnt ? bus.b1   : bus.b0;
        cin_r <= gnt ? bus.cin1 : bus.cin0;
        id_r  <= gnt;
        if (RR_EN) prio <= ~gnt;
      end
      if (state == LO) begin
        sum_r[15:0] <= add_s;
        carry_r     <= add_cout;
      end
      if (state == HI) begin
        sum_r[31:16] <= add_s;
        c_out_r      <= add_cout;
        ovf_r        <= (a_r[31] == b_r[31]) && (add_s[15] != a_r[31]);
      end
    end
  end

  assign bus.req_ready0 = rdy0;
  assign bus.req_ready1 = rdy1;
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_id    = id_r;
  assign bus.sum        = sum_r;
  assign bus.c_out      = c_out_r;
  assign bus.ovf        = ovf_r;
  assign bus.busy       = (state != IDLE);
endmodule

// File: doc/add_share_sched.md
ADD_SHARE_SCHED -- requirements
Module: add_share_sched

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req_valid0 / req_valid1, input, 1 each, request valid per requester.
REQ-005 The block SHALL have ports req_ready0 / req_ready1, output, 1 each, request accepted this cycle.
REQ-006 The block SHALL have ports a0, b0, a1, b1, input, 32 each, operands per requester.
REQ-007 The block SHALL have ports cin0 / cin1, input, 1 each, carry-in per requester.
REQ-008 The block SHALL have port resp_valid, output, 1, result available.
REQ-009 The block SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port resp_id, output, 1, requester that owns the current result.
REQ-011 The block SHALL have port sum, output, 32, registered 32-bit result.
REQ-012 The block SHALL have ports c_out and ovf, output, 1 each: unsigned carry-out and signed overflow.
REQ-013 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 The block SHALL instantiate exactly one 16-bit carry-lookahead adder core (CLA_16bit_withLCU) and time-share it for all arithmetic.
REQ-015 The FSM SHALL have states IDLE, LO, HI and DONE.
REQ-016 In IDLE, req_readyN SHALL be combinationally high only for the granted requester with req_validN high; all ready outputs SHALL be low in every other state.
REQ-017 Arbitration with both valid SHALL grant the requester holding priority; with one valid, that requester SHALL be granted regardless of priority.
REQ-018 With RR_EN=1, priority SHALL move to the non-granted requester after each accept; with RR_EN=0, requester 0 SHALL always hold priority.
REQ-019 On accept (IDLE and valid&ready), the block SHALL latch a, b, cin and the id at the clock edge, then move to LO.
REQ-020 In LO, the adder SHALL add a[15:0] + b[15:0] + cin; sum[15:0] and the internal carry SHALL be registered at the edge, then the FSM SHALL move to HI.
REQ-021 In HI, the adder SHALL add a[31:16] + b[31:16] + the registered carry; the block SHALL register sum[31:16] and c_out at the edge, set ovf = (a[31]==b[31]) and (sum[31]!=a[31]), then move to DONE.
REQ-022 In DONE, resp_valid SHALL be high; sum, c_out, ovf and resp_id SHALL be held stable until resp_valid and resp_ready are both high, then the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be exactly 3 cycles from the accept edge to resp_valid high; minimum throughput SHALL be one result per 4 cycles.
REQ-024 With resp_ready held low, DONE SHALL persist indefinitely, with no new accepts and outputs unchanged.
REQ-025 Requests arriving outside IDLE SHALL be ignored; operand changes after the accept edge SHALL NOT affect the result in flight.
REQ-026 Sum arithmetic SHALL wrap modulo 2^32, with the carry beyond bit 31 appearing only on c_out.

Reset
REQ-027 With rst high at a clock edge, state SHALL become IDLE, priority SHALL go to requester 0, and resp_valid, resp_id, sum, c_out and ovf SHALL all become 0.
REQ-028 Reset asserted in LO, HI or DONE SHALL discard the in-flight operation; no resp_valid SHALL follow for it.
REQ-029 During the cycle rst is high, req_ready0 and req_ready1 SHALL be low.

Verification
REQ-030 Bench: req0 only, a0=0x0000FFFF, b0=0x00000001, cin0=0 -> 3 cycles after accept: sum=0x00010000, c_out=0, ovf=0, resp_id=0.
REQ-031 Bench: req1, a1=0xFFFFFFFF, b1=0x00000000, cin1=1 -> sum=0x00000000, c_out=1, ovf=0, resp_id=1.
REQ-032 Bench: req0, a0=0x7FFFFFFF, b0=0x00000001, cin0=0 -> sum=0x80000000, c_out=0, ovf=1.
REQ-033 Bench: both requesters valid continuously, RR_EN=1 -> grants alternate 0,1,0,1, with accepts every 4 cycles when resp_ready=1; with RR_EN=0 -> grants are always 0.
REQ-034 Bench: resp_ready=0 for 5 cycles in DONE -> resp_valid and sum stay stable, both ready outputs stay low, and the FSM returns to IDLE one edge after resp_ready=1.
REQ-035 Bench: rst pulsed while in HI -> the next cycle is IDLE with outputs zero and no resp_valid; the next request completes normally.
